// File: rtl/pipelined_chunk_adder_if.sv
// ---------------------------------------------------------------------------
// pipelined_chunk_adder_if
//   Handshake and data bundle for pipelined_chunk_adder.
//
//   Input side  : in_valid / in_ready, operands a, b, carry-in cin, mode sub
//   Output side : out_valid / out_ready, result sum, carry cout, overflow ovf
//
//   master : the producer/consumer around the adder (drives operands and
//            out_ready, observes results)
//   slave  : the adder itself
// ---------------------------------------------------------------------------
interface pipelined_chunk_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_chunk_adder.sv
// ---------------------------------------------------------------------------
// pipelined_chunk_adder
//   WIDTH-bit add/subtract resolved CHUNK bits per pipeline rank, giving a
//   latency of STAGES = WIDTH/CHUNK cycles with one result per cycle and full
//   valid/ready backpressure. Chunk k is added by a small ripple adder placed
//   in front of rank k; each rank carries the untouched operand bits, the low
//   chunks already summed and the chunk's carry-out.
//
//   sub=0 : sum = a + b + cin
//   sub=1 : sum = a + ~b + 1   (cin ignored; cout=1 means no borrow)
//   ovf   : signed two's-complement overflow of the operation
//
// Ports
//   clk     rising-edge clock
//   arst_n  synchronous active-low reset (drops all in-flight work)
//   bus     pipelined_chunk_adder_if.slave (handshakes, operands, results)
//
// Parameters
//   WIDTH   operand/result width (>= 1)
//   CHUNK   bits per rank; 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0
//
// Optional feature (macro PIPELINED_CHUNK_ADDER_SAT_EN)
//   When defined, an overflowing result is replaced at the output by the
//   signed saturation value chosen by the sign of operand a.
// ---------------------------------------------------------------------------
module pipelined_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                    clk,
  input logic                    arst_n,
  pipelined_chunk_adder_if.slave bus
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("pipelined_chunk_adder: illegal WIDTH/CHUNK combination");
  end

  // Rank registers
  logic             valid_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];  // operand a, full width (upper bits still pending)
  logic [WIDTH-1:0] b_q     [STAGES];  // effective b (already inverted for subtract)
  logic [WIDTH-1:0] s_q     [STAGES];  // chunks 0..k summed
  logic             c_q     [STAGES];  // carry out of chunk k
  logic             ovf_q;

  // What feeds each rank, and what its chunk adder produces
  logic             v_src [STAGES];
  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] s_src [STAGES];
  logic             c_src [STAGES];
  logic [WIDTH-1:0] s_nxt [STAGES];
  logic             c_nxt [STAGES];
  logic             ovf_nxt;

  // adv[k]: rank k may load this cycle. adv[STAGES] is the output port.
  logic [STAGES:0]  adv;

  always_comb begin
    logic [CHUNK:0] chunk;
    // NOTE: every variable written here gets a value on every path first;
    // a path that leaves one unassigned would infer a latch.
    chunk = '0;

    // Backpressure ripples down from the output; an empty rank always loads,
    // so bubbles collapse even while the output is stalled.
    adv[STAGES] = !valid_q[LAST] || bus.out_ready;
    for (int k = LAST; k >= 0; k--) begin
      adv[k] = !valid_q[k] || adv[k+1];
    end

    // Subtraction becomes a + ~b + 1 right at entry; only the effective b
    // travels down the pipe.
    v_src[0] = bus.in_valid;
    a_src[0] = bus.a;
    b_src[0] = bus.sub ? ~bus.b : bus.b;
    s_src[0] = '0;
    c_src[0] = bus.sub ? 1'b1 : bus.cin;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k] = valid_q[k-1];
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      chunk = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
            + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
            + (CHUNK+1)'(c_src[k]);
      s_nxt[k]                  = s_src[k];
      s_nxt[k][k*CHUNK +: CHUNK] = chunk[CHUNK-1:0];
      c_nxt[k]                  = chunk[CHUNK];
    end

    // Carry-into-MSB XOR carry-out is the same as: both addends share a sign
    // and the result's sign differs from it. The sign form needs no tap
    // inside the final ripple chain and stays valid for CHUNK=1.
    ovf_nxt = (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1])
           && (s_nxt[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);
  end

  // NOTE: sequential state uses non-blocking assignments so every rank sees
  // the pre-edge value of the rank below, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      // NOTE: the rank data arrays are cleared too, not just the valid bits,
      // so sum/cout/ovf read zero during reset rather than stale results.
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        s_q[k]     <= '0;
        c_q[k]     <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          valid_q[k] <= v_src[k];
          // Data only moves with a valid transaction, so idle operand values
          // never disturb what the ranks hold.
          if (v_src[k]) begin
            a_q[k] <= a_src[k];
            b_q[k] <= b_src[k];
            s_q[k] <= s_nxt[k];
            c_q[k] <= c_nxt[k];
          end
        end
      end
      if (adv[LAST] && v_src[LAST]) begin
        ovf_q <= ovf_nxt;
      end
    end
  end

  assign bus.in_ready  = adv[0] && arst_n;
  assign bus.out_valid = valid_q[LAST];
  assign bus.cout      = c_q[LAST];
  assign bus.ovf       = ovf_q;

`ifdef PIPELINED_CHUNK_ADDER_SAT_EN
  // Overflow can only happen when the addends share a sign, so the sign of a
  // picks the clamp direction: 0 -> 0x7F..F, 1 -> 0x80..0.
  logic [WIDTH-1:0] sat_value;

  always_comb begin
    sat_value          = {WIDTH{~a_q[LAST][WIDTH-1]}};
    sat_value[WIDTH-1] = a_q[LAST][WIDTH-1];
  end

  assign bus.sum = ovf_q ? sat_value : s_q[LAST];
`else
  assign bus.sum = s_q[LAST];
`endif

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_chunk_adder
//   Self-checking bench for pipelined_chunk_adder (WIDTH=32, CHUNK=8).
//   Expected results come from signed/unsigned integer arithmetic on the
//   operands and are matched in order against every output transfer.
// ---------------------------------------------------------------------------
module tb_pipelined_chunk_adder;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int STAGES = WIDTH / CHUNK;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               acc;
    bit               chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic arst_n;

  pipelined_chunk_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int   tests    = 0;
  int   fails    = 0;
  int   cycle_no = 0;
  bit   lat_flag = 1'b0;
  exp_t exp_q[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    exp_t   e;
    longint sa, sb, r;
    longint unsigned ua, ub, usum;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = sub ? (sa - sb) : (sa + sb + longint'(cin));
    e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.sum = r[WIDTH-1:0];
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    usum = ua + ub + longint'(cin);
    e.cout = sub ? (a >= b) : usum[WIDTH];
`ifdef PIPELINED_CHUNK_ADDER_SAT_EN
    if (e.ovf) e.sum = a[WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    e.acc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  // One clock cycle: drive inputs, observe handshakes, score, advance.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic icin, input logic isub, input logic ordy,
                       output bit acc, output bit ofire);
    exp_t e;
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.cin       = icin;
    bus.sub       = isub;
    bus.out_ready = ordy;
    #1;
    acc   = iv && bus.in_ready;
    ofire = bus.out_valid && ordy;
    if (ofire) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", bus.out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("sum",  bus.sum,  e.sum);
        check("cout", bus.cout, e.cout);
        check("ovf",  bus.ovf,  e.ovf);
        if (e.chk_lat) check("latency", cycle_no - e.acc, STAGES);
      end
    end
    if (acc) begin
      e = model(ia, ib, icin, isub);
      e.acc = cycle_no;
      e.chk_lat = lat_flag;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cycle_no++;
  endtask

  task automatic send(input string tag, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                      input logic icin, input logic isub);
    bit acc, of;
    cycle(1'b1, ia, ib, icin, isub, 1'b1, acc, of);
    check(tag, acc, 1'b1);
  endtask

  task automatic drain();
    bit acc, of;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, of);
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit acc, of;
    int n_acc;

    arst_n        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with a live, nonzero request on the input
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, 1'b1, acc, of);
      check("rst_no_accept", acc, 1'b0);
    end
    check("rst_in_ready",  bus.in_ready,  1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_sum",       bus.sum,       32'h0);
    check("rst_cout",      bus.cout,      1'b0);
    check("rst_ovf",       bus.ovf,       1'b0);
    arst_n = 1'b1;
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, of);
    check("post_rst_in_ready", bus.in_ready, 1'b1);

    // Carry through every chunk boundary, with latency check
    lat_flag = 1'b1;
    send("acc_carry_chain", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    drain();

    // Subtract pair, back to back
    send("acc_sub_5_7",   32'd5,         32'd7, 1'b0, 1'b1);
    send("acc_sub_min_1", 32'h8000_0000, 32'd1, 1'b1, 1'b1);
    drain();

    // Signed add overflow
    send("acc_add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    drain();

    // Backpressure: out_ready low, pipe fills to exactly STAGES
    lat_flag = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(n_acc < 6, n_acc, n_acc, 1'b0, 1'b0, 1'b0, acc, of);
      if (acc) n_acc++;
    end
    check("bp_accepted", n_acc, STAGES);
    check("bp_in_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", bus.out_valid, 1'b1);
      check("bp_hold_sum",   bus.sum,       32'd0);
      check("bp_hold_cout",  bus.cout,      1'b0);
      cycle(1'b1, n_acc, n_acc, 1'b0, 1'b0, 1'b0, acc, of);
      if (acc) n_acc++;
    end
    check("bp_still_full", n_acc, STAGES);
    for (int i = 0; i < 6; i++) begin
      cycle(n_acc < 6, n_acc, n_acc, 1'b0, 1'b0, 1'b1, acc, of);
      if (acc) n_acc++;
      check("bp_one_per_cycle", of, 1'b1);
    end
    check("bp_total_accepted", n_acc, 6);
    drain();

    // Reset mid-stream drops the three in-flight transactions
    send("acc_flight0", 32'd100, 32'd1, 1'b0, 1'b0);
    send("acc_flight1", 32'd200, 32'd2, 1'b0, 1'b0);
    send("acc_flight2", 32'd300, 32'd3, 1'b0, 1'b0);
    arst_n = 1'b0;
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, of);
    exp_q.delete();
    arst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("rst_drop_no_out", bus.out_valid, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, of);
    end
    lat_flag = 1'b1;
    send("acc_after_rst", 32'h1234_0000, 32'h0000_5678, 1'b1, 1'b0);
    drain();

    // Randomised traffic with random backpressure and junk on idle inputs
    lat_flag = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0, acc, of);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_chunk_adder.md
Name: pipelined_chunk_adder

Overview:
Parametrised successor to the team's bit-serial pipelined ripple adder. It processes CHUNK bits per pipeline stage instead of one, so latency and register cost scale as WIDTH/CHUNK. It adds a subtract mode, signed-overflow detection and valid/ready flow control with full backpressure. It sits in datapath pipelines wherever a wide add/sub must close timing at high clock rates.

Parameters:
WIDTH, 32, operand and result width in bits; must be ≥1.
CHUNK, 8, bits resolved per pipeline stage; must satisfy 1 ≤ CHUNK ≤ WIDTH and WIDTH % CHUNK == 0. A violation is an elaboration error.
STAGES (localparam), WIDTH/CHUNK, number of pipeline ranks, which equals the latency in cycles.

Ports:
clk  in  1  clock; all state updates on the rising edge
arst_n  in  1  reset; synchronous, active-low
in_valid  in  1  input operands valid
in_ready  out  1  block can accept; a transfer occurs when in_valid & in_ready
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in; ignored when sub=1
sub  in  1  0: a+b+cin; 1: a-b, computed as a+~b+1
out_valid  out  1  result valid
out_ready  in  1  downstream accepts; a transfer occurs when out_valid & out_ready
sum  out  WIDTH  result
cout  out  1  raw carry out of bit WIDTH-1 (for sub=1, 1 means no borrow)
ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset: arst_n sampled low at a rising edge clears every rank's valid bit and data. While arst_n is low: in_ready=0, out_valid=0, sum=0, cout=0, ovf=0. The cycle after release, in_ready=1.
- Rank k (0..STAGES-1) holds:
  - the remaining operand bits,
  - low chunks 0..k already summed,
  - the carry out of chunk k,
  - a valid bit.
- Adder k is combinational ripple logic over bits [k*CHUNK +: CHUNK], placed in front of rank k.
- Chunk 0 uses effective b = sub ? ~b : b and carry-in = sub ? 1 : cin. Inversion is applied at entry, and the effective b propagates down the ranks.
- Latency: a transfer in cycle t gives out_valid=1 in cycle t+STAGES with the result. sum, cout and ovf come straight from the last rank's registers, with no output combinational logic beyond the optional saturation mux.
- ovf = carry into bit WIDTH-1 XOR cout, computed in the final chunk adder.
- Flow control per rank: advance_k = !valid_k | advance_{k+1}; advance_last = !out_valid | out_ready; in_ready = advance_0 (and arst_n high).
- Throughput: one result per cycle when out_ready stays 1.
- Stall: while out_valid & !out_ready, sum, cout and ovf hold stable and ranks fill upward without loss. in_ready drops only when all STAGES ranks are valid and the last is stalled.
- Bubbles collapse: an invalid rank accepts from the rank below even when downstream is stalled.
- Simultaneous accept at input and output in the same cycle with a full pipe is legal and sustains one per cycle.
- Ordering is strictly preserved.
- Input operands are sampled only on a transfer. Values on a/b/cin/sub when in_valid=0 have no effect.
- Reset mid-operation drops all in-flight transactions. No partial result is emitted.
- STAGES=1 degenerates to a single registered full-width ripple add with latency 1.

Optional Feature:
Macro PIPELINED_CHUNK_ADDER_SAT_EN.
- Defined: when ovf=1, sum is replaced at the output by the signed saturation value: 0x7F..F if the operand sign (bit WIDTH-1 of a) was 0, else 0x80..0. cout and ovf are unchanged. The mux is added after the last rank register with no extra latency, and the sign of a is carried to the last rank.
- Undefined: sum wraps modulo 2^WIDTH; no extra logic.

Test Plan:
- Reset with in_valid=1 and a,b nonzero -> while arst_n=0: in_ready=0, out_valid=0, sum=0, cout=0, ovf=0. In the cycle after release, in_ready=1.
- WIDTH=32, CHUNK=8: a=0xFFFFFFFF, b=0, cin=1, sub=0, out_ready=1, accepted cycle t -> cycle t+4: out_valid=1, sum=0x00000000, cout=1, ovf=0. Chunk-boundary carries are checked through all ranks.
- Subtract, two transfers:
  - a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x80000000, b=1, sub=1 -> cout=1, ovf=1, sum=0x7FFFFFFF without the macro, 0x80000000 with PIPELINED_CHUNK_ADDER_SAT_EN.
- Backpressure: stream 6 transfers of a=i, b=i, cin=0 with out_ready=0 from the first out_valid -> in_ready=0 after exactly 4 accepted, outputs held stable. out_ready then raised -> results 0,2,4,6,8,10 emitted in order, one per cycle, none lost or duplicated.
- Add overflow: a=0x7FFFFFFF, b=1, cin=0, sub=0 -> ovf=1, cout=0, sum=0x80000000 without the macro, 0x7FFFFFFF with it.
- Reset mid-stream: 3 transactions in flight, arst_n low for 1 cycle -> no out_valid for those transactions. A new transfer after release gives its result 4 cycles later.
